psg_stereo_mixer: RTL and testbench

Parametrised PSG channel mixer and 1-bit audio output stage for the Oric core. It takes the AY-3-8912 per-channel levels and routes them to left/right according to a preset or custom pan map. Each side is scaled by a master volume and drives its own first-order sigma-delta DAC to the board audio pins. It generalises the fixed mono/ABC/ACB mix plus separate DAC instances: variable channel count and input width, custom panning, volume and mute, sample-aligned mode switching, and a registered pipeline.

---
 rtl/psg_stereo_mixer.sv | 131 +++++++++++++
 tb/tb_psg_stereo_mixer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/psg_stereo_mixer.sv
// rtl/psg_stereo_mixer.sv - PSG channel stereo mixer with master volume and per-side sigma-delta DAC
module psg_stereo_mixer #(
  parameter int CHANNELS = 3,
  parameter int IN_W     = 8,
  parameter int OUT_W    = IN_W + 2
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     sample_ce,
  input  logic [CHANNELS*IN_W-1:0] ch_in,
  input  logic [1:0]               stereo_mode,
  input  logic [2*CHANNELS-1:0]    pan_map,
  input  logic [3:0]               master_vol,
  input  logic                     mute,
  output logic [OUT_W-1:0]         pcm_l,
  output logic [OUT_W-1:0]         pcm_r,
  output logic                     pcm_valid,
  output logic                     dac_l,
  output logic                     dac_r
);

  localparam int PROD_W = OUT_W + 4;

  localparam logic [1:0] MODE_MONO   = 2'b00;
  localparam logic [1:0] MODE_ABC    = 2'b01;
  localparam logic [1:0] MODE_CUSTOM = 2'b11;

  logic [2*CHANNELS-1:0]    pan_dec;
  logic [CHANNELS*IN_W-1:0] ch_q;
  logic [2*CHANNELS-1:0]    pan_q;
  logic [3:0]               vol_q, vol2;
  logic                     mute_q, mute2;
  logic                     v1, v2;
  logic [OUT_W-1:0]         sum_l_c, sum_r_c, sum_l, sum_r;
  logic [PROD_W-1:0]        gain, prod_l, prod_r;
  logic [OUT_W:0]           acc_l, acc_r;

  // Per-channel L/R enables: bit0 = left, bit1 = right.
  always_comb begin
    pan_dec = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (stereo_mode == MODE_MONO) begin
        pan_dec[2*i +: 2] = 2'b11;
      end else if (stereo_mode == MODE_CUSTOM) begin
        pan_dec[2*i +: 2] = pan_map[2*i +: 2];
      end else if (CHANNELS == 2) begin
        pan_dec[2*i +: 2] = (i == 0) ? 2'b01 : 2'b10;
      end else if (i == 0) begin
        pan_dec[2*i +: 2] = 2'b01;
      end else if (i == 1) begin
        pan_dec[2*i +: 2] = (stereo_mode == MODE_ABC) ? 2'b11 : 2'b10;
      end else if (i == 2) begin
        pan_dec[2*i +: 2] = (stereo_mode == MODE_ABC) ? 2'b10 : 2'b11;
      end else begin
        pan_dec[2*i +: 2] = 2'b11;
      end
    end
  end

  always_comb begin
    sum_l_c = '0;
    sum_r_c = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (pan_q[2*i])
        sum_l_c = sum_l_c + OUT_W'(ch_q[i*IN_W +: IN_W]);
      if (pan_q[2*i+1])
        sum_r_c = sum_r_c + OUT_W'(ch_q[i*IN_W +: IN_W]);
    end
  end

  always_comb begin
    gain   = PROD_W'(vol2) + PROD_W'(1);
    prod_l = PROD_W'(sum_l) * gain;
    prod_r = PROD_W'(sum_r) * gain;
  end

  // Controls are captured with the sample so mode/volume switch on sample boundaries.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ch_q      <= '0;
      pan_q     <= '0;
      vol_q     <= '0;
      mute_q    <= 1'b0;
      v1        <= 1'b0;
      sum_l     <= '0;
      sum_r     <= '0;
      vol2      <= '0;
      mute2     <= 1'b0;
      v2        <= 1'b0;
      pcm_l     <= '0;
      pcm_r     <= '0;
      pcm_valid <= 1'b0;
    end else begin
      v1 <= sample_ce;
      if (sample_ce) begin
        ch_q   <= ch_in;
        pan_q  <= pan_dec;
        vol_q  <= master_vol;
        mute_q <= mute;
      end
      v2 <= v1;
      if (v1) begin
        sum_l <= sum_l_c;
        sum_r <= sum_r_c;
        vol2  <= vol_q;
        mute2 <= mute_q;
      end
      pcm_valid <= v2;
      if (v2) begin
        pcm_l <= mute2 ? '0 : prod_l[PROD_W-1:4];
        pcm_r <= mute2 ? '0 : prod_r[PROD_W-1:4];
      end
    end
  end

  // First-order sigma-delta: the carry out of the accumulator is the bitstream.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      acc_l <= '0;
      acc_r <= '0;
      dac_l <= 1'b0;
      dac_r <= 1'b0;
    end else begin
      acc_l <= {1'b0, acc_l[OUT_W-1:0]} + {1'b0, pcm_l};
      acc_r <= {1'b0, acc_r[OUT_W-1:0]} + {1'b0, pcm_r};
      dac_l <= acc_l[OUT_W];
      dac_r <= acc_r[OUT_W];
    end
  end

endmodule

// File: tb/tb_psg_stereo_mixer.sv
// tb/tb_psg_stereo_mixer.sv - directed-vector bench for psg_stereo_mixer (3- and 4-channel builds)
module tb_psg_stereo_mixer;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        sample_ce;
  logic [23:0] ch_in;
  logic [31:0] ch_in4;
  logic [1:0]  stereo_mode;
  logic [5:0]  pan_map;
  logic [7:0]  pan_map4;
  logic [3:0]  master_vol;
  logic        mute;
  logic [9:0]  pcm_l, pcm_r, pcm_l4, pcm_r4;
  logic        pcm_valid, dac_l, dac_r, pcm_valid4, dac_l4, dac_r4;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk_sys = ~clk_sys;

  psg_stereo_mixer #(.CHANNELS(3), .IN_W(8)) dut (
    .clk_sys(clk_sys), .reset(reset), .sample_ce(sample_ce), .ch_in(ch_in),
    .stereo_mode(stereo_mode), .pan_map(pan_map), .master_vol(master_vol), .mute(mute),
    .pcm_l(pcm_l), .pcm_r(pcm_r), .pcm_valid(pcm_valid), .dac_l(dac_l), .dac_r(dac_r)
  );

  psg_stereo_mixer #(.CHANNELS(4), .IN_W(8)) dut4 (
    .clk_sys(clk_sys), .reset(reset), .sample_ce(sample_ce), .ch_in(ch_in4),
    .stereo_mode(stereo_mode), .pan_map(pan_map4), .master_vol(master_vol), .mute(mute),
    .pcm_l(pcm_l4), .pcm_r(pcm_r4), .pcm_valid(pcm_valid4), .dac_l(dac_l4), .dac_r(dac_r4)
  );

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Strobe once; report pcm at n+3 and whether pcm_valid was a single pulse exactly there.
  task automatic run_sample(output logic [9:0] l, output logic [9:0] r, output bit timing_ok);
    timing_ok = 1'b1;
    sample_ce = 1'b1;
    tick();
    sample_ce = 1'b0;
    if (pcm_valid !== 1'b0) timing_ok = 1'b0;
    tick();
    if (pcm_valid !== 1'b0) timing_ok = 1'b0;
    tick();
    if (pcm_valid !== 1'b1) timing_ok = 1'b0;
    l = pcm_l;
    r = pcm_r;
    tick();
    if (pcm_valid !== 1'b0) timing_ok = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_vec++;
    if ({pcm_l, pcm_r, pcm_valid, dac_l, dac_r} !== 23'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got l=%h r=%h v=%b dl=%b dr=%b, want all 0",
               pcm_l, pcm_r, pcm_valid, dac_l, dac_r);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_mono();
    logic [9:0] l, r;
    bit ok;
    stereo_mode = 2'b00; master_vol = 4'd15;
    ch_in = {8'h30, 8'h20, 8'h10};
    run_sample(l, r, ok);
    n_vec++;
    if (!ok) begin n_bad++; $display("FAIL mono_timing: pcm_valid not a single pulse at n+3, want pulse"); end
    n_vec++;
    if (l !== 10'h060 || r !== 10'h060) begin
      n_bad++; $display("FAIL mono_value: got l=%h r=%h, want 060/060", l, r);
    end
    master_vol = 4'd0;
    run_sample(l, r, ok);
    n_vec++;
    if (l !== 10'h006 || r !== 10'h006) begin
      n_bad++; $display("FAIL vol0_value: got l=%h r=%h, want 006/006", l, r);
    end
  endtask

  task automatic test_abc_acb();
    logic [9:0] l, r;
    bit ok;
    master_vol = 4'd15; stereo_mode = 2'b01;
    ch_in = {8'h80, 8'h01, 8'hFF};
    sample_ce = 1'b1;
    tick();
    sample_ce = 1'b0;
    stereo_mode = 2'b10;
    master_vol = 4'd0;
    tick();
    tick();
    n_vec++;
    if (pcm_valid !== 1'b1 || pcm_l !== 10'h100 || pcm_r !== 10'h081) begin
      n_bad++;
      $display("FAIL abc_value: got v=%b l=%h r=%h, want 1/100/081", pcm_valid, pcm_l, pcm_r);
    end
    tick();
    master_vol = 4'd15;
    run_sample(l, r, ok);
    n_vec++;
    if (!ok || l !== 10'h17F || r !== 10'h081) begin
      n_bad++; $display("FAIL acb_value: got l=%h r=%h ok=%0d, want 17F/081 ok=1", l, r, ok);
    end
  endtask

  task automatic test_custom();
    logic [9:0] l, r;
    bit ok;
    stereo_mode = 2'b11; pan_map = 6'b10_00_01; master_vol = 4'd7;
    ch_in = {8'hFF, 8'hFF, 8'hFF};
    run_sample(l, r, ok);
    n_vec++;
    if (l !== 10'h07F || r !== 10'h07F) begin
      n_bad++; $display("FAIL custom_value: got l=%h r=%h, want 07F/07F", l, r);
    end
  endtask

  task automatic test_full_scale();
    logic [9:0] l, r;
    bit ok;
    int ones;
    stereo_mode = 2'b00; master_vol = 4'd15;
    ch_in4 = 32'hFFFF_FFFF;
    run_sample(l, r, ok);
    n_vec++;
    if (pcm_l4 !== 10'h3FC || pcm_r4 !== 10'h3FC) begin
      n_bad++; $display("FAIL full_scale_value: got l=%h r=%h, want 3FC/3FC", pcm_l4, pcm_r4);
    end
    repeat (4) tick();
    ones = 0;
    for (int i = 0; i < 1024; i++) begin
      if (dac_l4 === 1'b1) ones++;
      tick();
    end
    n_vec++;
    if (ones < 1019 || ones > 1021) begin
      n_bad++; $display("FAIL dac_density: got %0d ones in 1024, want 1020 +-1", ones);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp_v [3];
    logic [23:0] dat [3];
    stereo_mode = 2'b00; master_vol = 4'd15;
    dat[0] = 24'h03_02_01; exp_v[0] = 10'h006;
    dat[1] = 24'h00_00_10; exp_v[1] = 10'h010;
    dat[2] = 24'hFF_FF_FF; exp_v[2] = 10'h2FD;
    for (int i = 0; i < 3; i++) begin
      ch_in = dat[i];
      sample_ce = 1'b1;
      tick();
    end
    sample_ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (pcm_valid !== 1'b1 || pcm_l !== exp_v[i] || pcm_r !== exp_v[i]) begin
        n_bad++;
        $display("FAIL b2b_%0d: got v=%b l=%h r=%h, want 1/%h/%h", i, pcm_valid, pcm_l, pcm_r, exp_v[i], exp_v[i]);
      end
      tick();
    end
    n_vec++;
    if (pcm_valid !== 1'b0) begin
      n_bad++; $display("FAIL b2b_end: got v=%b, want 0", pcm_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] l, r;
    bit ok, seen;
    ch_in = 24'h11_22_33;
    sample_ce = 1'b1;
    tick();
    sample_ce = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (pcm_valid !== 1'b0 || pcm_l !== 10'd0 || pcm_r !== 10'd0 || dac_l !== 1'b0) seen = 1'b1;
      tick();
    end
    n_vec++;
    if (seen) begin
      n_bad++; $display("FAIL reset_mid: got a pulse or nonzero output after reset, want none");
    end
    run_sample(l, r, ok);
    n_vec++;
    if (!ok || l !== 10'h066 || r !== 10'h066) begin
      n_bad++; $display("FAIL reset_first: got l=%h r=%h ok=%0d, want 066/066 ok=1", l, r, ok);
    end
  endtask

  task automatic test_mute();
    logic [9:0] l, r;
    bit ok, seen;
    ch_in = 24'hC0_C0_C0;
    mute = 1'b1;
    run_sample(l, r, ok);
    n_vec++;
    if (l !== 10'd0 || r !== 10'd0) begin
      n_bad++; $display("FAIL mute_value: got l=%h r=%h, want 000/000", l, r);
    end
    tick();
    tick();
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (dac_l !== 1'b0 || dac_r !== 1'b0) seen = 1'b1;
      tick();
    end
    n_vec++;
    if (seen) begin
      n_bad++; $display("FAIL mute_dac: got dac ones after flush, want 0");
    end
    mute = 1'b0;
  endtask

  initial begin
    reset = 1'b1; sample_ce = 1'b0; ch_in = '0; ch_in4 = '0;
    stereo_mode = 2'b00; pan_map = '0; pan_map4 = '0; master_vol = 4'd15; mute = 1'b0;
    test_reset();
    test_mono();
    test_abc_acb();
    test_custom();
    test_full_scale();
    test_back_to_back();
    test_reset_mid();
    test_mute();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
